// File: rtl/fht_ctrl.sv
// Stage/address sequencer for the in-place radix-2 FHT engine: one butterfly issue per cycle, writes delayed RD_LAT+2.
// Optional FHT_CTRL_SEL_EN adds oSEL, the stage-0 trivial-twiddle select.
module fht_ctrl #(
  parameter int N      = 256,
  parameter int A_BIT  = 8,
  parameter int RD_LAT = 1
) (
  input  logic                       iCLK,
  input  logic                       iRESET,
  input  logic                       iSTART,
  output logic                       oBUSY,
  output logic                       oDONE,
  output logic [$clog2(A_BIT)-1:0]   oSTAGE,
  output logic                       oBANK,
  output logic                       oRD_EN,
  output logic [A_BIT-1:0]           oRD_ADDR_1,
  output logic [A_BIT-1:0]           oRD_ADDR_2,
  output logic                       oRD_EN_0,
  output logic [A_BIT-1:0]           oRD_ADDR_0,
  output logic [A_BIT-2:0]           oW_ADDR,
  output logic                       oWR_EN,
  output logic [A_BIT-1:0]           oWR_ADDR_0,
  output logic [A_BIT-1:0]           oWR_ADDR_1
`ifdef FHT_CTRL_SEL_EN
  ,output logic                      oSEL
`endif
);

  localparam int SW   = $clog2(A_BIT);
  localparam int D    = RD_LAT + 2;
  localparam int DW   = $clog2(D);
  localparam int HALF = N / 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [A_BIT-1:0] cnt;
  logic [DW-1:0]    dcnt;
  logic [A_BIT-1:0] rd_x0;

  logic             issue;
  logic [SW-1:0]    iss_s;
  logic [A_BIT-1:0] iss_cnt, h, k, b, x0, x1, x2;
  logic [A_BIT-2:0] w;

  logic             en_pipe [D];
  logic [A_BIT-1:0] x0_pipe [D];
  logic [A_BIT-1:0] x1_pipe [D];

  // Select the (stage, cnt) of the butterfly that the coming edge will issue, if any.
  always_comb begin
    issue   = 1'b0;
    iss_s   = oSTAGE;
    iss_cnt = cnt;
    case (state)
      IDLE: begin
        issue   = iSTART;
        iss_s   = '0;
        iss_cnt = '0;
      end
      RUN:   issue = (cnt != A_BIT'(HALF));
      DRAIN: begin
        issue   = (dcnt == DW'(D - 1)) && (oSTAGE != SW'(A_BIT - 1));
        iss_s   = oSTAGE + SW'(1);
        iss_cnt = '0;
      end
      default: issue = 1'b0;
    endcase
    h  = A_BIT'(1) << iss_s;
    k  = iss_cnt & (h - A_BIT'(1));
    b  = ((iss_cnt >> iss_s) << iss_s) << 1;
    x0 = b + k;
    x1 = b + h + k;
    x2 = b + h + ((h - k) & (h - A_BIT'(1)));
    w  = (A_BIT-1)'(k << (SW'(A_BIT - 1) - iss_s));
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state  <= IDLE;
      oSTAGE <= '0;
      cnt    <= '0;
      dcnt   <= '0;
      oBANK  <= 1'b0;
      oBUSY  <= 1'b0;
      oDONE  <= 1'b0;
    end else begin
      oDONE <= 1'b0;
      case (state)
        IDLE: if (iSTART) begin
          state  <= RUN;
          oSTAGE <= '0;
          oBANK  <= 1'b0;
          oBUSY  <= 1'b1;
          cnt    <= A_BIT'(1);
        end
        RUN: begin
          if (cnt == A_BIT'(HALF)) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            cnt <= cnt + A_BIT'(1);
          end
        end
        DRAIN: begin
          if (dcnt != DW'(D - 1)) begin
            dcnt <= dcnt + DW'(1);
          end else if (oSTAGE == SW'(A_BIT - 1)) begin
            state <= DONE;
            oBUSY <= 1'b0;
            oDONE <= 1'b1;
          end else begin
            state  <= RUN;
            oSTAGE <= oSTAGE + SW'(1);
            oBANK  <= ~oBANK;
            cnt    <= A_BIT'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FHT_CTRL_SEL_EN
  logic sel_q;
  assign oSEL = sel_q;
`endif

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      oRD_EN     <= 1'b0;
      oRD_ADDR_1 <= '0;
      oRD_ADDR_2 <= '0;
      oW_ADDR    <= '0;
      rd_x0      <= '0;
`ifdef FHT_CTRL_SEL_EN
      sel_q      <= 1'b0;
`endif
    end else begin
      oRD_EN <= issue;
      if (issue) begin
        oRD_ADDR_1 <= x1;
        oRD_ADDR_2 <= x2;
        oW_ADDR    <= w;
        rd_x0      <= x0;
      end
`ifdef FHT_CTRL_SEL_EN
      sel_q <= issue && (iss_s == '0);
`endif
    end
  end

  // Stage 0 of the shift pipeline doubles as the one-cycle X_0 read delay.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      for (int i = 0; i < D; i++) begin
        en_pipe[i] <= 1'b0;
        x0_pipe[i] <= '0;
        x1_pipe[i] <= '0;
      end
    end else begin
      en_pipe[0] <= oRD_EN;
      x0_pipe[0] <= rd_x0;
      x1_pipe[0] <= oRD_ADDR_1;
      for (int i = 1; i < D; i++) begin
        en_pipe[i] <= en_pipe[i-1];
        x0_pipe[i] <= x0_pipe[i-1];
        x1_pipe[i] <= x1_pipe[i-1];
      end
    end
  end

  assign oRD_EN_0   = en_pipe[0];
  assign oRD_ADDR_0 = x0_pipe[0];
  assign oWR_EN     = en_pipe[D-1];
  assign oWR_ADDR_0 = x0_pipe[D-1];
  assign oWR_ADDR_1 = x1_pipe[D-1];

endmodule

// File: tb/tb_fht_ctrl.sv
// Bench for fht_ctrl at N=16, RD_LAT=1: per-cycle issue/write scoreboard plus scenario tasks.
module tb_fht_ctrl;
  localparam int N      = 16;
  localparam int A_BIT  = 4;
  localparam int RD_LAT = 1;
  localparam int D      = RD_LAT + 2;
  localparam int SLEN   = N/2 + D;

  logic       iCLK = 1'b0;
  logic       iRESET;
  logic       iSTART;
  logic       oBUSY, oDONE, oBANK, oRD_EN, oRD_EN_0, oWR_EN;
  logic [1:0] oSTAGE;
  logic [3:0] oRD_ADDR_1, oRD_ADDR_2, oRD_ADDR_0, oWR_ADDR_0, oWR_ADDR_1;
  logic [2:0] oW_ADDR;
`ifdef FHT_CTRL_SEL_EN
  logic       oSEL;
`endif

  fht_ctrl #(.N(N), .A_BIT(A_BIT), .RD_LAT(RD_LAT)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
    .oBUSY(oBUSY), .oDONE(oDONE), .oSTAGE(oSTAGE), .oBANK(oBANK),
    .oRD_EN(oRD_EN), .oRD_ADDR_1(oRD_ADDR_1), .oRD_ADDR_2(oRD_ADDR_2),
    .oRD_EN_0(oRD_EN_0), .oRD_ADDR_0(oRD_ADDR_0), .oW_ADDR(oW_ADDR),
    .oWR_EN(oWR_EN), .oWR_ADDR_0(oWR_ADDR_0), .oWR_ADDR_1(oWR_ADDR_1)
`ifdef FHT_CTRL_SEL_EN
    , .oSEL(oSEL)
`endif
  );

  always #5 iCLK = ~iCLK;

  typedef struct { int cyc; int s; int x0; int x1; int x2; int w; } rd_t;
  typedef struct { int cyc; int x0; int x1; } wr_t;

  rd_t rd_q[$];
  wr_t wr_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc_cnt = 0;
  bit  mon_on = 1'b0;
  bit  prev_rd = 1'b0;
  int  prev_x0 = 0;

  always @(posedge iCLK) cyc_cnt = cyc_cnt + 1;

  // Expected issues enumerated group-by-group, butterfly index cnt = g*H + k.
  task automatic push_transform(input int t0);
    for (int s = 0; s < A_BIT; s++) begin
      int h;
      h = 1 << s;
      for (int g = 0; g < N/(2*h); g++) begin
        for (int k = 0; k < h; k++) begin
          rd_t r;
          wr_t wv;
          r.cyc = t0 + 1 + s*SLEN + g*h + k;
          r.s   = s;
          r.x0  = g*2*h + k;
          r.x1  = r.x0 + h;
          r.x2  = g*2*h + h + ((h - k) % h);
          r.w   = k * (N/2) / h;
          rd_q.push_back(r);
          wv.cyc = r.cyc + D;
          wv.x0  = r.x0;
          wv.x1  = r.x1;
          wr_q.push_back(wv);
        end
      end
    end
  endtask

  always @(negedge iCLK) begin
    bit  exp_rd, exp_wr;
    rd_t r;
    wr_t wv;
    if (mon_on) begin
      if (!iRESET) prev_rd = 1'b0;
      exp_rd = (rd_q.size() > 0) && (rd_q[0].cyc == cyc_cnt);
      checks++;
      if (oRD_EN !== exp_rd) begin
        errors++;
        $display("FAIL rd_en cyc=%0d got=%b exp=%b", cyc_cnt, oRD_EN, exp_rd);
      end
      if (exp_rd) begin
        r = rd_q.pop_front();
        checks++;
        if ({oSTAGE, oBANK, oRD_ADDR_1, oRD_ADDR_2, oW_ADDR} !==
            {2'(r.s), 1'(r.s % 2), 4'(r.x1), 4'(r.x2), 3'(r.w)}) begin
          errors++;
          $display("FAIL issue cyc=%0d got s=%0d bank=%0d x1=%0d x2=%0d w=%0d exp s=%0d bank=%0d x1=%0d x2=%0d w=%0d",
                   cyc_cnt, oSTAGE, oBANK, oRD_ADDR_1, oRD_ADDR_2, oW_ADDR, r.s, r.s % 2, r.x1, r.x2, r.w);
        end
      end
      checks++;
      if (oRD_EN_0 !== prev_rd) begin
        errors++;
        $display("FAIL rd_en_0 cyc=%0d got=%b exp=%b", cyc_cnt, oRD_EN_0, prev_rd);
      end
      if (prev_rd) begin
        checks++;
        if (oRD_ADDR_0 !== 4'(prev_x0)) begin
          errors++;
          $display("FAIL rd_addr_0 cyc=%0d got=%0d exp=%0d", cyc_cnt, oRD_ADDR_0, prev_x0);
        end
      end
      prev_rd = exp_rd;
      if (exp_rd) prev_x0 = r.x0;
`ifdef FHT_CTRL_SEL_EN
      checks++;
      if (oSEL !== (exp_rd && r.s == 0)) begin
        errors++;
        $display("FAIL sel cyc=%0d got=%b exp=%b", cyc_cnt, oSEL, exp_rd && r.s == 0);
      end
`endif
      exp_wr = (wr_q.size() > 0) && (wr_q[0].cyc == cyc_cnt);
      checks++;
      if (oWR_EN !== exp_wr) begin
        errors++;
        $display("FAIL wr_en cyc=%0d got=%b exp=%b", cyc_cnt, oWR_EN, exp_wr);
      end
      if (exp_wr) begin
        wv = wr_q.pop_front();
        checks++;
        if ({oWR_ADDR_0, oWR_ADDR_1} !== {4'(wv.x0), 4'(wv.x1)}) begin
          errors++;
          $display("FAIL wr_addr cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc_cnt, oWR_ADDR_0, oWR_ADDR_1, wv.x0, wv.x1);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    checks++;
    if ({oBUSY, oDONE, oSTAGE, oBANK, oRD_EN, oRD_ADDR_1, oRD_ADDR_2, oRD_EN_0,
         oRD_ADDR_0, oW_ADDR, oWR_EN, oWR_ADDR_0, oWR_ADDR_1} !== '0) begin
      errors++;
      $display("FAIL %s outputs not zero: busy=%b done=%b s=%0d bank=%b rd=%b wr=%b", tag,
               oBUSY, oDONE, oSTAGE, oBANK, oRD_EN, oWR_EN);
    end
`ifdef FHT_CTRL_SEL_EN
    checks++;
    if (oSEL !== 1'b0) begin
      errors++;
      $display("FAIL %s sel got=%b exp=0", tag, oSEL);
    end
`endif
  endtask

  task automatic test_reset();
    iRESET = 1'b0;
    iSTART = 1'b0;
    repeat (2) @(negedge iCLK);
    check_all_zero("reset");
    #1 iRESET = 1'b1;
    repeat (2) @(negedge iCLK);
    check_all_zero("post_reset_idle");
    mon_on = 1'b1;
  endtask

  task automatic test_transform(input bit restart);
    int t0;
    @(negedge iCLK);
    t0 = cyc_cnt;
    iSTART = 1'b1;
    push_transform(t0);
    for (int rel = 1; rel <= 50; rel++) begin
      @(negedge iCLK);
      iSTART = restart && (rel == 5 || rel == 30);
      checks++;
      if (oBUSY !== (rel <= 44)) begin
        errors++;
        $display("FAIL busy rel=%0d got=%b exp=%b", rel, oBUSY, rel <= 44);
      end
      checks++;
      if (oDONE !== (rel == 45)) begin
        errors++;
        $display("FAIL done rel=%0d got=%b exp=%b", rel, oDONE, rel == 45);
      end
      if (rel == 14 || rel == 24) begin
        checks++;
        if ({oRD_ADDR_1, oRD_ADDR_2, oW_ADDR} !== ((rel == 14) ? {4'd6, 4'd6, 3'd0} : {4'd5, 4'd7, 3'd2})) begin
          errors++;
          $display("FAIL example rel=%0d got x1=%0d x2=%0d w=%0d", rel, oRD_ADDR_1, oRD_ADDR_2, oW_ADDR);
        end
      end
      if (rel == 15 || rel == 25) begin
        checks++;
        if (oRD_ADDR_0 !== ((rel == 15) ? 4'd4 : 4'd1)) begin
          errors++;
          $display("FAIL example_x0 rel=%0d got=%0d exp=%0d", rel, oRD_ADDR_0, (rel == 15) ? 4 : 1);
        end
      end
      if (rel == 45) begin
        checks++;
        if (oBANK !== 1'b1) begin
          errors++;
          $display("FAIL bank_hold got=%b exp=1", oBANK);
        end
      end
    end
    iSTART = 1'b0;
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL drained leftover rd=%0d wr=%0d exp=0/0", rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge iCLK);
    iSTART = 1'b1;
    push_transform(cyc_cnt);
    @(negedge iCLK);
    iSTART = 1'b0;
    repeat (19) @(negedge iCLK);
    #1 iRESET = 1'b0;
    rd_q.delete();
    wr_q.delete();
    #1 check_all_zero("reset_mid_a");
    @(negedge iCLK);
    #1 check_all_zero("reset_mid_b");
    @(negedge iCLK);
    #1 iRESET = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge iCLK);
      checks++;
      if ({oWR_EN, oRD_EN, oBUSY, oDONE} !== 4'b0) begin
        errors++;
        $display("FAIL after_reset i=%0d wr=%b rd=%b busy=%b done=%b exp all 0", i, oWR_EN, oRD_EN, oBUSY, oDONE);
      end
    end
  endtask

  initial begin
    test_reset();
    test_transform(1'b0);
    test_transform(1'b1);
    test_reset_midrun();
    test_transform(1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
